// File: rtl/freq_meter_pkg.sv
// Shared types and defaults for the frequency / duty meter.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/freq_meter_sync_edge_det.sv
// Synchronizes an asynchronous input and emits one-cycle rise/fall pulses.
module sync_edge_det
  import freq_meter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Pulses appear SYNC_STAGES+1 cycles after the input edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_o <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall_o <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

endmodule

// File: rtl/freq_meter.sv
// Measures period and high time of a slow asynchronous input in clk_i cycles,
// single-shot or continuously, with a saturation timeout.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             sig_i,
  input  logic             start_i,
  input  logic             cont_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             timeout_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_d, high_d;
  logic             timeout_d;
  logic             rise, fall;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .sig_i  (sig_i),
    .rise_o (rise),
    .fall_o (fall)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state, counter and result updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_o;
    high_d    = high_o;
    timeout_d = timeout_o;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = ARM;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end
      end
      ARM: begin
        if (rise) begin
          state_d = MEAS;
          cnt_d   = CNT_W'(1);
        end else if (cnt_q == CNT_MAX) begin
          state_d   = DONE;
          period_d  = '0;
          high_d    = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MEAS: begin
        if (fall) high_d = cnt_q;
        if (rise) begin
          state_d   = DONE;
          period_d  = cnt_q;
          timeout_d = 1'b0;
          cnt_d     = CNT_W'(1);
        end else if (cnt_q == CNT_MAX) begin
          state_d   = DONE;
          period_d  = '0;
          high_d    = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        // The closing rise opens the next period; DONE is its second cycle.
        if (cont_i && timeout_o) begin
          state_d = ARM;
          cnt_d   = '0;
        end else if (cont_i) begin
          state_d = MEAS;
          cnt_d   = CNT_W'(2);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q     <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      period_o  <= '0;
      high_o    <= '0;
      timeout_o <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      busy_o    <= (state_d == ARM) || (state_d == MEAS);
      done_o    <= (state_d == DONE);
      period_o  <= period_d;
      high_o    <= high_d;
      timeout_o <= timeout_d;
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench: event-level reference model of the meter over a scripted
// plus random stimulus timeline, compared against the DUT every cycle.
module tb_freq_meter;

  localparam int unsigned CNT_W = 8;
  localparam int MAXC = 255;
  localparam int N    = 4000;
  localparam int LAT  = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             sig = 1'b0;
  logic             start = 1'b0;
  logic             cont = 1'b0;
  logic             busy, done, timeout;
  logic [CNT_W-1:0] period, high;

  freq_meter #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .clk_i    (clk),
    .reset_i  (reset),
    .sig_i    (sig),
    .start_i  (start),
    .cont_i   (cont),
    .busy_o   (busy),
    .done_o   (done),
    .period_o (period),
    .high_o   (high),
    .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  // Stimulus timeline, one entry per clk cycle.
  bit sig_w [N];
  bit st_w  [N];
  bit ct_w  [N];
  bit rs_w  [N];
  // Synchronized edge events as seen by the meter.
  bit rz [N];
  bit fz [N];
  // Expected outputs per cycle.
  bit e_busy [N];
  bit e_done [N];
  bit e_to   [N];
  int e_per  [N];
  int e_hi   [N];

  int checks   = 0;
  int failures = 0;
  int cur      = -1;
  int hi_e;
  int m_per, m_hi, m_to;

  task automatic check(string nm, int act, int exp, int cyc);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic periodic(int from, int to, int h, int l);
    for (int c = from; c < to; c++) sig_w[c] = ((c - from) % (h + l)) < h;
  endtask

  task automatic emit(int c, bit b, bit d);
    if (c < hi_e) begin
      e_busy[c] = b;
      e_done[c] = d;
      e_per[c]  = m_per;
      e_hi[c]   = m_hi;
      e_to[c]   = m_to[0];
    end
  endtask

  task automatic emit_busy(int a, int b);
    for (int k = a; k <= b && k < hi_e; k++) emit(k, 1'b1, 1'b0);
  endtask

  function automatic int find_ev(bit want_rise, int a, int b);
    for (int k = a; k <= b && k < hi_e; k++)
      if (want_rise ? rz[k] : fz[k]) return k;
    return -1;
  endfunction

  // Expected behaviour over one reset-free stretch [lo, hi).
  task automatic fill_epoch(int lo, int hi);
    int c, arm, t0, nx, r2, f, d, lim;
    bit in_meas;
    hi_e  = hi;
    m_per = 0;
    m_hi  = 0;
    m_to  = 0;
    c = lo;
    t0 = 0;
    nx = 0;
    while (c < hi) begin
      emit(c, 1'b0, 1'b0);
      if (!st_w[c]) begin
        c++;
        continue;
      end
      m_to    = 0;
      arm     = c + 1;
      in_meas = 1'b0;
      c       = -1;
      while (c < 0) begin
        d = -1;
        if (!in_meas) begin
          t0 = find_ev(1'b1, arm, arm + MAXC);
          if (t0 >= 0) begin
            emit_busy(arm, t0);
            nx      = t0 + 1;
            in_meas = 1'b1;
          end else begin
            emit_busy(arm, arm + MAXC);
            m_per = 0; m_hi = 0; m_to = 1;
            d = arm + MAXC + 1;
          end
        end else begin
          r2  = find_ev(1'b1, nx, t0 + MAXC);
          lim = (r2 >= 0) ? r2 : t0 + MAXC;
          f   = find_ev(1'b0, nx, lim);
          if (f >= 0) begin
            emit_busy(nx, f);
            m_hi = f - t0;
            emit_busy(f + 1, lim);
          end else begin
            emit_busy(nx, lim);
          end
          if (r2 >= 0) begin
            m_per = r2 - t0;
            m_to  = 0;
            d     = r2 + 1;
            t0    = r2;
            nx    = r2 + 2;
          end else begin
            m_per = 0; m_hi = 0; m_to = 1;
            d = t0 + MAXC + 1;
            in_meas = 1'b0;
          end
        end
        if (d >= hi || (d < 0 && nx >= hi && in_meas)) begin
          c = hi;
        end else if (d >= 0) begin
          emit(d, 1'b0, 1'b1);
          if (!ct_w[d])  c = d + 1;
          else if (m_to != 0) begin
            in_meas = 1'b0;
            arm     = d + 1;
          end
        end
      end
    end
  endtask

  task automatic build_model();
    int c, e;
    for (int k = 0; k < N; k++) begin
      rz[k] = (k >= LAT + 1) && sig_w[k-LAT] && !sig_w[k-LAT-1];
      fz[k] = (k >= LAT + 1) && !sig_w[k-LAT] && sig_w[k-LAT-1];
    end
    c = 0;
    while (c < N) begin
      if (rs_w[c]) begin
        e_busy[c] = 1'b0; e_done[c] = 1'b0; e_to[c] = 1'b0;
        e_per[c]  = 0;    e_hi[c]   = 0;
        c++;
      end else begin
        e = c;
        while (e < N && !rs_w[e]) e++;
        fill_epoch(c, e);
        c = e;
      end
    end
  endtask

  task automatic build_stimulus();
    int c, h, l;
    for (int k = 0; k < 5; k++) rs_w[k] = 1'b1;
    periodic(20, 110, 4, 4);      st_w[30] = 1'b1;
    periodic(120, 220, 3, 7);     st_w[130] = 1'b1;
    st_w[240] = 1'b1;             st_w[300] = 1'b1;
    periodic(540, 800, 6, 6);     st_w[550] = 1'b1;
    for (int k = 545; k < 700; k++) ct_w[k] = 1'b1;
    periodic(810, 1000, 8, 12);
    st_w[820] = 1'b1; st_w[830] = 1'b1; st_w[840] = 1'b1;
    periodic(1015, 1200, 5, 25);  st_w[1020] = 1'b1; st_w[1070] = 1'b1;
    for (int k = 1058; k <= 1062; k++) rs_w[k] = 1'b1;
    c = 1210;
    while (c < 3880) begin
      h = int'($urandom_range(2, 20));
      l = ($urandom_range(0, 19) == 0) ? int'($urandom_range(200, 300))
                                       : int'($urandom_range(2, 20));
      for (int k = c; k < c + h && k < 3880; k++) sig_w[k] = 1'b1;
      c += h + l;
    end
    for (int k = 1210; k < 3900; k++) st_w[k] = ($urandom_range(0, 29) == 0);
    for (int b = 1210; b < N; b += 64) begin
      bit cv;
      cv = 1'(($urandom_range(0, 1)));
      for (int k = b; k < b + 64 && k < N; k++) ct_w[k] = cv;
    end
  endtask

  // Hand-derived anchor points for the model itself.
  task automatic pin_model();
    check("model_a_done", int'(e_done[40]), 1, 40);
    check("model_a_period", e_per[40], 8, 40);
    check("model_a_high", e_hi[40], 4, 40);
    check("model_a_timeout", int'(e_to[40]), 0, 40);
    check("model_b_busy_start", int'(e_busy[131]), 1, 131);
    check("model_b_period", e_per[144], 10, 144);
    check("model_b_high", e_hi[144], 3, 144);
    check("model_to_done", int'(e_done[497]), 1, 497);
    check("model_to_flag", int'(e_to[497]), 1, 497);
    check("model_to_period", e_per[497], 0, 497);
    check("model_cont_gap", int'(e_done[574]), 0, 574);
    check("model_cont_period", e_per[580], 12, 580);
    check("model_cont_high", e_hi[580], 6, 580);
    check("model_cont_last", int'(e_done[700]), 1, 700);
    check("model_cont_idle", int'(e_busy[701]), 0, 701);
    check("model_busy_start_period", e_per[854], 20, 854);
    check("model_rst_busy", int'(e_busy[1060]), 0, 1060);
    check("model_rst_period", e_per[1109], 30, 1109);
    check("model_rst_high", e_hi[1109], 5, 1109);
  endtask

  always @(negedge clk) begin
    if (cur >= 0) begin
      check("busy", int'(busy), int'(e_busy[cur]), cur);
      check("done", int'(done), int'(e_done[cur]), cur);
      check("period", int'(period), e_per[cur], cur);
      check("high", int'(high), e_hi[cur], cur);
      check("timeout", int'(timeout), int'(e_to[cur]), cur);
    end
  end

  initial begin
    build_stimulus();
    build_model();
    pin_model();
    for (int c = 0; c < N; c++) begin
      @(posedge clk);
      #1;
      reset = rs_w[c];
      sig   = sig_w[c];
      start = st_w[c];
      cont  = ct_w[c];
      cur   = c;
    end
    @(posedge clk);
    #1;
    cur = -1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
